// File: rtl/ex_pkg.sv
// Shared constants for the MIPS execute stage: ALU / HI-LO opcodes, control-word bit map, back-bus layout.
// Latency: n/a (declarations plus one combinational helper).
// Backpressure: n/a.
package ex_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_OR    = 4'd3;
  localparam logic [3:0] ALU_XOR   = 4'd4;
  localparam logic [3:0] ALU_NOR   = 4'd5;
  localparam logic [3:0] ALU_SLL   = 4'd6;
  localparam logic [3:0] ALU_SRL   = 4'd7;
  localparam logic [3:0] ALU_SRA   = 4'd8;
  localparam logic [3:0] ALU_SLLV  = 4'd9;
  localparam logic [3:0] ALU_SRLV  = 4'd10;
  localparam logic [3:0] ALU_SRAV  = 4'd11;
  localparam logic [3:0] ALU_LUI   = 4'd12;
  localparam logic [3:0] ALU_SLTU  = 4'd13;
  localparam logic [3:0] ALU_PASSB = 4'd14;
  localparam logic [3:0] ALU_PASSA = 4'd15;

  // HI/LO unit operation codes
  localparam logic [2:0] MD_NONE = 3'd0;
  localparam logic [2:0] MD_MULT = 3'd1;
  localparam logic [2:0] MD_DIV  = 3'd2;
  localparam logic [2:0] MD_MTHI = 3'd3;
  localparam logic [2:0] MD_MTLO = 3'd4;

  // ex_ctrl bit positions
  localparam int CTL_CP0WB      = 15;
  localparam int CTL_CP0WRITE   = 14;
  localparam int CTL_REGDST     = 13;
  localparam int CTL_ISSLT      = 12;
  localparam int CTL_SAVEPC     = 11;
  localparam int CTL_ALUSRC     = 10;
  localparam int CTL_ALUOP_MSB  = 9;
  localparam int CTL_ALUOP_LSB  = 6;
  localparam int CTL_MDSIGN     = 5;
  localparam int CTL_MDFUNC_MSB = 4;
  localparam int CTL_MDFUNC_LSB = 2;
  localparam int CTL_MDHIWB     = 1;
  localparam int CTL_MDLOWB     = 0;

  // Back-bus {we, reg, data} field offsets
  localparam int BK_WE       = 37;
  localparam int BK_REG_MSB  = 36;
  localparam int BK_REG_LSB  = 32;
  localparam int BK_DATA_MSB = 31;
  localparam int BK_DATA_LSB = 0;

  // Operand bypass: MEM beats WB, and $0 always reads from the register file
  function automatic logic [31:0] fwd_operand(input logic [4:0]  src,
                                              input logic [37:0] mem_b,
                                              input logic [37:0] wb_b,
                                              input logic [31:0] rf_val);
    if (mem_b[BK_WE] && (mem_b[BK_REG_MSB:BK_REG_LSB] == src) && (src != 5'd0))
      return mem_b[BK_DATA_MSB:BK_DATA_LSB];
    else if (wb_b[BK_WE] && (wb_b[BK_REG_MSB:BK_REG_LSB] == src) && (src != 5'd0))
      return wb_b[BK_DATA_MSB:BK_DATA_LSB];
    else
      return rf_val;
  endfunction

endpackage

// File: rtl/ex_md_unit.sv
// HI/LO register pair with multiply, optional divide (macro EX_DIV_EN) and MTHI/MTLO.
// Latency: result lands in HI/LO at the clock edge; readers see it from the next cycle.
// Backpressure: none; single-cycle combinational multiply/divide, never stalls.
module ex_md_unit
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  i_func,
  input  logic        i_sign,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // Sign- or zero-extending to 64 bits lets one unsigned multiply serve both MULT and MULTU
  logic [63:0] w_a_ext;
  logic [63:0] w_b_ext;
  logic [63:0] w_prod;
  assign w_a_ext = {{32{i_sign & i_a[31]}}, i_a};
  assign w_b_ext = {{32{i_sign & i_b[31]}}, i_b};
  assign w_prod  = w_a_ext * w_b_ext;

  logic        w_div_vld;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

`ifdef EX_DIV_EN
  // Divide on magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000 rem 0.
  logic        w_a_neg;
  logic        w_b_neg;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [31:0] w_q_mag;
  logic [31:0] w_r_mag;
  assign w_a_neg   = i_sign & i_a[31];
  assign w_b_neg   = i_sign & i_b[31];
  assign w_a_mag   = w_a_neg ? (32'd0 - i_a) : i_a;
  assign w_b_mag   = w_b_neg ? (32'd0 - i_b) : i_b;
  assign w_div_vld = (i_b != 32'd0);
  assign w_q_mag   = w_div_vld ? (w_a_mag / w_b_mag) : 32'd0;
  assign w_r_mag   = w_div_vld ? (w_a_mag % w_b_mag) : 32'd0;
  assign w_quot    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem     = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
`else
  assign w_div_vld = 1'b0;
  assign w_quot    = 32'd0;
  assign w_rem     = 32'd0;
`endif

  // HI/LO update; divide by zero (or divider absent) leaves both registers untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else begin
      case (i_func)
        MD_MULT: begin
          r_hi <= w_prod[63:32];
          r_lo <= w_prod[31:0];
        end
        MD_DIV: begin
          if (w_div_vld) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end
        end
        MD_MTHI: r_hi <= i_a;
        MD_MTLO: r_lo <= i_a;
        default: ;
      endcase
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/ex_stage_core.sv
// MIPS execute stage: operand bypass, ALU, HI/LO unit, result/destination select, EX/MEM register. Divider gated by macro EX_DIV_EN.
// Latency: one cycle to EX/MEM outputs; rw and cp0_wr are combinational.
// Backpressure: none; ex_flush bubbles the control outputs while mem_data holds.
module ex_stage_core
  import ex_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_flush,
  input  logic [15:0]  ex_ctrl,
  input  logic         mem_ctrl_in,
  input  logic [4:0]   wb_ctrl_in,
  input  logic [157:0] ex_data,
  input  logic [37:0]  mem_back,
  input  logic [37:0]  wb_back,
  input  logic [31:0]  cp0_rdata,
  output logic         mem_ctrl_out,
  output logic [4:0]   wb_ctrl_out,
  output logic [68:0]  mem_data,
  output logic [37:0]  cp0_wr,
  output logic [4:0]   rw
);

  logic [29:0] w_pcp1;
  logic [31:0] w_instr;
  logic [31:0] w_rd1;
  logic [31:0] w_rd2;
  logic [31:0] w_extb;
  assign w_pcp1  = ex_data[157:128];
  assign w_instr = ex_data[127:96];
  assign w_rd1   = ex_data[95:64];
  assign w_rd2   = ex_data[63:32];
  assign w_extb  = ex_data[31:0];

  // Opcode and funct fields were consumed upstream in decode
  logic w_unused_instr;
  assign w_unused_instr = &{1'b0, w_instr[31:26], w_instr[5:0]};

  logic [3:0] w_aluop;
  logic [2:0] w_mdfunc;
  logic [4:0] w_sa;
  assign w_aluop  = ex_ctrl[CTL_ALUOP_MSB:CTL_ALUOP_LSB];
  assign w_mdfunc = ex_ctrl[CTL_MDFUNC_MSB:CTL_MDFUNC_LSB];
  assign w_sa     = w_instr[10:6];

  logic [31:0] w_f_rd1;
  logic [31:0] w_f_rd2;
  logic [31:0] w_a;
  logic [31:0] w_b;
  assign w_f_rd1 = fwd_operand(w_instr[25:21], mem_back, wb_back, w_rd1);
  assign w_f_rd2 = fwd_operand(w_instr[20:16], mem_back, wb_back, w_rd2);
  assign w_a     = w_f_rd1;
  assign w_b     = ex_ctrl[CTL_ALUSRC] ? w_extb : w_f_rd2;

  // ALU; arithmetic wraps, no overflow detection
  logic [31:0] w_alu;
  always_comb begin
    w_alu = w_b;
    case (w_aluop)
      ALU_ADD:   w_alu = w_a + w_b;
      ALU_SUB:   w_alu = w_a - w_b;
      ALU_AND:   w_alu = w_a & w_b;
      ALU_OR:    w_alu = w_a | w_b;
      ALU_XOR:   w_alu = w_a ^ w_b;
      ALU_NOR:   w_alu = ~(w_a | w_b);
      ALU_SLL:   w_alu = w_b << w_sa;
      ALU_SRL:   w_alu = w_b >> w_sa;
      ALU_SRA:   w_alu = $unsigned($signed(w_b) >>> w_sa);
      ALU_SLLV:  w_alu = w_b << w_a[4:0];
      ALU_SRLV:  w_alu = w_b >> w_a[4:0];
      ALU_SRAV:  w_alu = $unsigned($signed(w_b) >>> w_a[4:0]);
      ALU_LUI:   w_alu = w_b << 16;
      ALU_SLTU:  w_alu = {31'd0, (w_a < w_b)};
      ALU_PASSB: w_alu = w_b;
      ALU_PASSA: w_alu = w_a;
      default:   w_alu = w_b;
    endcase
  end

  logic [31:0] w_hi;
  logic [31:0] w_lo;
  ex_md_unit u_md (
    .clk    (clk),
    .rst    (rst),
    .i_func (w_mdfunc),
    .i_sign (ex_ctrl[CTL_MDSIGN]),
    .i_a    (w_a),
    .i_b    (w_b),
    .o_hi   (w_hi),
    .o_lo   (w_lo)
  );

  // Stage result select; a true signed compare avoids the A-B overflow pitfall of SLT
  logic [31:0] w_exout;
  always_comb begin
    w_exout = w_alu;
    if (ex_ctrl[CTL_ISSLT])       w_exout = {31'd0, ($signed(w_a) < $signed(w_b))};
    else if (ex_ctrl[CTL_SAVEPC]) w_exout = {w_pcp1, 2'b00};
    else if (ex_ctrl[CTL_CP0WB])  w_exout = cp0_rdata;
    else if (ex_ctrl[CTL_MDHIWB]) w_exout = w_hi;
    else if (ex_ctrl[CTL_MDLOWB]) w_exout = w_lo;
  end

  // Destination register: link register for JAL, rd for R-type, rt otherwise
  logic [4:0] w_rw;
  always_comb begin
    w_rw = w_instr[20:16];
    if (ex_ctrl[CTL_SAVEPC] && !ex_ctrl[CTL_REGDST]) w_rw = 5'd31;
    else if (ex_ctrl[CTL_REGDST])                   w_rw = w_instr[15:11];
  end

  assign rw     = w_rw;
  assign cp0_wr = {ex_ctrl[CTL_CP0WRITE], w_instr[15:11], w_f_rd2};

  logic        r_mem_ctrl;
  logic [4:0]  r_wb_ctrl;
  logic [68:0] r_mem_data;

  // EX/MEM register; a flush only kills control, datapath contents are don't-care and held
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_ctrl <= 1'b0;
      r_wb_ctrl  <= 5'd0;
      r_mem_data <= 69'd0;
    end else if (ex_flush) begin
      r_mem_ctrl <= 1'b0;
      r_wb_ctrl  <= 5'd0;
    end else begin
      r_mem_ctrl <= mem_ctrl_in;
      r_wb_ctrl  <= wb_ctrl_in;
      r_mem_data <= {w_rw, w_exout, w_f_rd2};
    end
  end

  assign mem_ctrl_out = r_mem_ctrl;
  assign wb_ctrl_out  = r_wb_ctrl;
  assign mem_data     = r_mem_data;

endmodule

// File: tb/tb_ex_stage_core.sv
// Testbench for ex_stage_core: vector table plus HI/LO, flush and reset sequences.
// Latency: expectations queued at drive time, popped one clock later.
// Backpressure: n/a.
module tb_ex_stage_core;
  import ex_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_flush;
  logic [15:0]  ex_ctrl;
  logic         mem_ctrl_in;
  logic [4:0]   wb_ctrl_in;
  logic [157:0] ex_data;
  logic [37:0]  mem_back;
  logic [37:0]  wb_back;
  logic [31:0]  cp0_rdata;
  logic         mem_ctrl_out;
  logic [4:0]   wb_ctrl_out;
  logic [68:0]  mem_data;
  logic [37:0]  cp0_wr;
  logic [4:0]   rw;

  ex_stage_core dut (
    .clk          (clk),
    .rst          (rst),
    .ex_flush     (ex_flush),
    .ex_ctrl      (ex_ctrl),
    .mem_ctrl_in  (mem_ctrl_in),
    .wb_ctrl_in   (wb_ctrl_in),
    .ex_data      (ex_data),
    .mem_back     (mem_back),
    .wb_back      (wb_back),
    .cp0_rdata    (cp0_rdata),
    .mem_ctrl_out (mem_ctrl_out),
    .wb_ctrl_out  (wb_ctrl_out),
    .mem_data     (mem_data),
    .cp0_wr       (cp0_wr),
    .rw           (rw)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        flush;
    logic [15:0] ctrl;
    logic        mci;
    logic [4:0]  wci;
    logic [29:0] pcp1;
    logic [31:0] instr;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] extb;
    logic [31:0] cp0;
    logic [37:0] mb;
    logic [37:0] wbk;
    logic [4:0]  e_rw;
    logic [31:0] e_exout;
    logic [31:0] e_frd2;
  } vec_t;

  typedef struct {
    string       name;
    logic        mctl;
    logic [4:0]  wctl;
    logic [68:0] md;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [68:0] last_md  = '0;

  function automatic logic [15:0] mk_ctrl(input logic cp0wb, input logic cp0write, input logic regdst,
                                          input logic isslt, input logic savepc, input logic alusrc,
                                          input logic [3:0] aluop, input logic mdsign, input logic [2:0] mdfunc,
                                          input logic mdhiwb, input logic mdlowb);
    return {cp0wb, cp0write, regdst, isslt, savepc, alusrc, aluop, mdsign, mdfunc, mdhiwb, mdlowb};
  endfunction

  function automatic logic [31:0] mk_instr(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sa);
    return {6'd0, rs, rt, rd, sa, 6'd0};
  endfunction

  function automatic logic [37:0] mk_back(input logic we, input logic [4:0] r, input logic [31:0] d);
    return {we, r, d};
  endfunction

  function automatic vec_t mkv(input string name, input logic [15:0] ctrl, input logic [31:0] instr,
                               input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] extb,
                               input logic [37:0] mb, input logic [37:0] wbk,
                               input logic [4:0] e_rw, input logic [31:0] e_exout, input logic [31:0] e_frd2);
    vec_t v;
    v.name = name; v.rst = 1'b0; v.flush = 1'b0; v.ctrl = ctrl;
    v.mci = 1'b1; v.wci = 5'h0A; v.pcp1 = '0; v.instr = instr;
    v.rd1 = rd1; v.rd2 = rd2; v.extb = extb; v.cp0 = '0;
    v.mb = mb; v.wbk = wbk; v.e_rw = e_rw; v.e_exout = e_exout; v.e_frd2 = e_frd2;
    return v;
  endfunction

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle, check combinational outputs, queue the registered expectation, compare after the edge
  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    rst         = v.rst;
    ex_flush    = v.flush;
    ex_ctrl     = v.ctrl;
    mem_ctrl_in = v.mci;
    wb_ctrl_in  = v.wci;
    ex_data     = {v.pcp1, v.instr, v.rd1, v.rd2, v.extb};
    mem_back    = v.mb;
    wb_back     = v.wbk;
    cp0_rdata   = v.cp0;
    #1;
    check({v.name, " rw"}, 69'(rw), 69'(v.e_rw));
    check({v.name, " cp0_wr"}, 69'(cp0_wr), 69'({v.ctrl[14], v.instr[15:11], v.e_frd2}));
    e.name = v.name;
    if (v.rst) begin
      e.mctl = 1'b0; e.wctl = 5'd0; e.md = '0;
    end else if (v.flush) begin
      e.mctl = 1'b0; e.wctl = 5'd0; e.md = last_md;
    end else begin
      e.mctl = v.mci; e.wctl = v.wci; e.md = {v.e_rw, v.e_exout, v.e_frd2};
    end
    last_md = e.md;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({got.name, " mem_ctrl_out"}, 69'(mem_ctrl_out), 69'(got.mctl));
    check({got.name, " wb_ctrl_out"}, 69'(wb_ctrl_out), 69'(got.wctl));
    check({got.name, " mem_data"}, mem_data, got.md);
  endtask

  // HI/LO operation or read: A=rd1 via rs=1, B=extb; exout is a read of HI/LO or else A+B
  task automatic md_op(input string name, input logic [2:0] func, input logic sign,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic hiwb, input logic lowb, input logic [31:0] e_rd, input logic flush);
    vec_t v;
    logic [31:0] e_out;
    e_out = (hiwb || lowb) ? e_rd : (a + b);
    v = mkv(name, mk_ctrl(0, 0, 0, 0, 0, 1, ALU_ADD, sign, func, hiwb, lowb), mk_instr(1, 0, 0, 0),
            a, 32'd0, b, '0, '0, 5'd0, e_out, 32'd0);
    v.flush = flush;
    v.wci   = 5'h1F;
    apply(v);
  endtask

  logic [31:0] e_hi1, e_lo1, e_hi3, e_lo3;
  vec_t        vr;

  initial begin
    rst = 1'b1; ex_flush = 1'b0; ex_ctrl = '0; mem_ctrl_in = 1'b0; wb_ctrl_in = '0;
    ex_data = '0; mem_back = '0; wb_back = '0; cp0_rdata = '0;
    repeat (2) @(posedge clk);
    #1;

    vr = mkv("reset", 16'd0, 32'd0, 32'd0, 32'd0, 32'd0, '0, '0, 5'd0, 32'd0, 32'd0);
    vr.rst = 1'b1;
    apply(vr);

    tbl.push_back(mkv("fwd_mem", mk_ctrl(0,0,0,0,0,1,ALU_ADD,0,MD_NONE,0,0), mk_instr(5,0,0,0),
                      32'd1, 32'h33, 32'd2, mk_back(1,5,32'h10), mk_back(1,5,32'h20), 5'd0, 32'h12, 32'h33));
    tbl.push_back(mkv("fwd_wb", mk_ctrl(0,0,0,0,0,1,ALU_ADD,0,MD_NONE,0,0), mk_instr(5,0,0,0),
                      32'd1, 32'h33, 32'd2, mk_back(0,5,32'h10), mk_back(1,5,32'h20), 5'd0, 32'h22, 32'h33));
    tbl.push_back(mkv("fwd_r0", mk_ctrl(0,0,0,0,0,1,ALU_ADD,0,MD_NONE,0,0), mk_instr(0,0,0,0),
                      32'd0, 32'h33, 32'd2, mk_back(1,0,32'h10), mk_back(1,0,32'h20), 5'd0, 32'h02, 32'h33));
    tbl.push_back(mkv("slt", mk_ctrl(0,0,0,1,0,1,ALU_ADD,0,MD_NONE,0,0), mk_instr(1,3,0,0),
                      32'hFFFFFFFF, 32'h44, 32'd1, '0, '0, 5'd3, 32'd1, 32'h44));
    tbl.push_back(mkv("sltu", mk_ctrl(0,0,0,0,0,1,ALU_SLTU,0,MD_NONE,0,0), mk_instr(1,3,0,0),
                      32'hFFFFFFFF, 32'h44, 32'd1, '0, '0, 5'd3, 32'd0, 32'h44));
    tbl.push_back(mkv("sra", mk_ctrl(0,0,0,0,0,0,ALU_SRA,0,MD_NONE,0,0), mk_instr(1,2,0,4),
                      32'd0, 32'h80000000, 32'd0, '0, '0, 5'd2, 32'hF8000000, 32'h80000000));
    tbl.push_back(mkv("sub", mk_ctrl(0,0,0,0,0,1,ALU_SUB,0,MD_NONE,0,0), mk_instr(1,0,0,0),
                      32'd5, 32'd0, 32'd7, '0, '0, 5'd0, 32'hFFFFFFFE, 32'd0));
    tbl.push_back(mkv("nor", mk_ctrl(0,0,0,0,0,1,ALU_NOR,0,MD_NONE,0,0), mk_instr(1,0,0,0),
                      32'hF0F0F0F0, 32'd0, 32'h0F0F0000, '0, '0, 5'd0, 32'h00000F0F, 32'd0));
    tbl.push_back(mkv("srlv", mk_ctrl(0,0,0,0,0,1,ALU_SRLV,0,MD_NONE,0,0), mk_instr(1,0,0,0),
                      32'd4, 32'd0, 32'h80, '0, '0, 5'd0, 32'h8, 32'd0));
    tbl.push_back(mkv("lui", mk_ctrl(0,0,0,0,0,1,ALU_LUI,0,MD_NONE,0,0), mk_instr(1,0,0,0),
                      32'd0, 32'd0, 32'h1234, '0, '0, 5'd0, 32'h12340000, 32'd0));
    tbl.push_back(mkv("sll", mk_ctrl(0,0,0,0,0,0,ALU_SLL,0,MD_NONE,0,0), mk_instr(1,2,0,8),
                      32'd0, 32'h000000FF, 32'd0, '0, '0, 5'd2, 32'h0000FF00, 32'h000000FF));
    tbl.push_back(mkv("fwd_rt_wb_cp0w", mk_ctrl(0,1,0,0,0,0,ALU_PASSB,0,MD_NONE,0,0), mk_instr(1,7,3,0),
                      32'd0, 32'h99, 32'd0, mk_back(1,6,32'h77), mk_back(1,7,32'hABCD), 5'd7, 32'hABCD, 32'hABCD));
    tbl.push_back(mkv("fwd_rt_mem", mk_ctrl(0,0,0,0,0,0,ALU_PASSB,0,MD_NONE,0,0), mk_instr(1,7,3,0),
                      32'd0, 32'h99, 32'd0, mk_back(1,7,32'h1111), mk_back(1,7,32'h2222), 5'd7, 32'h1111, 32'h1111));
    tbl.push_back(mkv("jal", mk_ctrl(0,0,0,0,1,0,ALU_ADD,0,MD_NONE,0,0), mk_instr(1,2,9,0),
                      32'd0, 32'h5, 32'd0, '0, '0, 5'd31, 32'h00400004, 32'h5));
    tbl.push_back(mkv("jalr", mk_ctrl(0,0,1,0,1,0,ALU_ADD,0,MD_NONE,0,0), mk_instr(1,2,9,0),
                      32'd0, 32'h5, 32'd0, '0, '0, 5'd9, 32'h00400004, 32'h5));
    tbl.push_back(mkv("mfc0", mk_ctrl(1,0,0,0,0,0,ALU_ADD,0,MD_NONE,0,0), mk_instr(0,4,0,0),
                      32'd0, 32'd0, 32'd0, '0, '0, 5'd4, 32'hDEADBEEF, 32'd0));
    tbl.push_back(mkv("slt_over_savepc", mk_ctrl(0,0,0,1,1,1,ALU_ADD,0,MD_NONE,0,0), mk_instr(1,0,0,0),
                      32'd1, 32'd0, 32'd2, '0, '0, 5'd31, 32'd1, 32'd0));
    tbl[13].pcp1 = 30'h00100001;
    tbl[14].pcp1 = 30'h00100001;
    tbl[15].cp0  = 32'hDEADBEEF;
    tbl[16].pcp1 = 30'h00100001;

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      v.mci = i[0];
      v.wci = 5'(i + 3);
      apply(v);
    end

    // Multiply; the read in the same cycle as the write still sees the previous value
    md_op("mult_s_rd_old_hi", MD_MULT, 1, 32'hFFFFFFFE, 32'd3, 1, 0, 32'd0, 0);
    md_op("mult_s_hi", MD_NONE, 0, 32'd0, 32'd0, 1, 0, 32'hFFFFFFFF, 0);
    md_op("mult_s_lo", MD_NONE, 0, 32'd0, 32'd0, 0, 1, 32'hFFFFFFFA, 0);
    md_op("mult_u_rd_old_lo", MD_MULT, 0, 32'hFFFFFFFE, 32'd3, 0, 1, 32'hFFFFFFFA, 0);
    md_op("mult_u_hi", MD_NONE, 0, 32'd0, 32'd0, 1, 0, 32'd2, 0);
    md_op("mult_u_lo", MD_NONE, 0, 32'd0, 32'd0, 0, 1, 32'hFFFFFFFA, 0);
    md_op("mthi", MD_MTHI, 0, 32'h11111111, 32'd0, 0, 0, 32'd0, 0);
    md_op("mtlo", MD_MTLO, 0, 32'h22222222, 32'd0, 0, 0, 32'd0, 0);
    md_op("mthi_rd", MD_NONE, 0, 32'd0, 32'd0, 1, 0, 32'h11111111, 0);
    md_op("mtlo_rd", MD_NONE, 0, 32'd0, 32'd0, 0, 1, 32'h22222222, 0);

`ifdef EX_DIV_EN
    e_hi1 = 32'hFFFFFFFF; e_lo1 = 32'hFFFFFFFD; e_hi3 = 32'h00000000; e_lo3 = 32'h80000000;
`else
    e_hi1 = 32'h11111111; e_lo1 = 32'h22222222; e_hi3 = 32'h11111111; e_lo3 = 32'h22222222;
`endif
    md_op("div_neg7_2", MD_DIV, 1, 32'hFFFFFFF9, 32'd2, 0, 0, 32'd0, 0);
    md_op("div_neg7_2_hi", MD_NONE, 0, 32'd0, 32'd0, 1, 0, e_hi1, 0);
    md_op("div_neg7_2_lo", MD_NONE, 0, 32'd0, 32'd0, 0, 1, e_lo1, 0);
    md_op("div_by0", MD_DIV, 1, 32'd5, 32'd0, 0, 0, 32'd0, 0);
    md_op("div_by0_hi", MD_NONE, 0, 32'd0, 32'd0, 1, 0, e_hi1, 0);
    md_op("div_by0_lo", MD_NONE, 0, 32'd0, 32'd0, 0, 1, e_lo1, 0);
    md_op("div_min_m1", MD_DIV, 1, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'd0, 0);
    md_op("div_min_m1_hi", MD_NONE, 0, 32'd0, 32'd0, 1, 0, e_hi3, 0);
    md_op("div_min_m1_lo", MD_NONE, 0, 32'd0, 32'd0, 0, 1, e_lo3, 0);

    // Flush bubbles control, holds mem_data, and does not block the HI/LO write
    apply(tbl[0]);
    md_op("flush_mthi", MD_MTHI, 0, 32'h5555, 32'd0, 0, 0, 32'd0, 1);
    md_op("flush_mthi_rd", MD_NONE, 0, 32'd0, 32'd0, 1, 0, 32'h5555, 0);

    // Reset wins over flush and clears HI/LO
    vr = tbl[11];
    vr.rst = 1'b1; vr.flush = 1'b1; vr.wci = 5'h1F;
    apply(vr);
    md_op("rst_hi", MD_NONE, 0, 32'd0, 32'd0, 1, 0, 32'd0, 0);
    md_op("rst_lo", MD_NONE, 0, 32'd0, 32'd0, 0, 1, 32'd0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
